muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one bit per cycle.
// In: clk_i, rst_i (sync, active-low), start_i, flush_i, funct3_i,
//     RS1data_i, RS2data_i, RDaddr_i.
// Out: busy_o, done_o, RDaddr_o, RDdata_o, RegWrite_o.
// Define MULDIV_DIV_EN to build the divider; otherwise ops 4-7
// finish immediately with no write-back.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] RS1data_i,
  input  logic [XLEN-1:0] RS2data_i,
  input  logic [4:0]      RDaddr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [4:0]      RDaddr_o,
  output logic [XLEN-1:0] RDdata_o,
  output logic            RegWrite_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic            r_neg;
  logic [4:0]      r_rd;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_rd_q;
  logic [XLEN-1:0] r_data_q;
`ifdef MULDIV_DIV_EN
  logic            r_dz;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN:0]   w_rsh;
  logic            w_ge;
  logic [XLEN-1:0] w_dif;
  logic [XLEN-1:0] w_rem_nx;
`endif

  logic              w_accept;
  logic              w_skip;
  logic              w_done;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic              w_neg;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_pfix;
  logic [XLEN-1:0]   w_result;

  // Operand signedness per op; magnitudes feed the unsigned core.
  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    unique case (funct3_i)
      3'd1, 3'd4, 3'd6: begin
        w_a_sgn = RS1data_i[XLEN-1];
        w_b_sgn = RS2data_i[XLEN-1];
      end
      3'd2: w_a_sgn = RS1data_i[XLEN-1];
      default: ;
    endcase
  end

  // A remainder follows the dividend; everything else is sa^sb.
  assign w_neg = (funct3_i == 3'd6) ? w_a_sgn
                                    : (w_a_sgn ^ w_b_sgn);
  assign w_mag_a = w_a_sgn ? -RS1data_i : RS1data_i;
  assign w_mag_b = w_b_sgn ? -RS2data_i : RS2data_i;

`ifdef MULDIV_DIV_EN
  assign w_skip = 1'b0;
`else
  assign w_skip = funct3_i[2];
`endif

  assign w_accept = (r_state == IDLE) && start_i && !flush_i;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_i) w_next = w_skip ? DONE : CALC;
      end
      CALC: begin
        if (r_cnt == CW'(XLEN-1)) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush_i) w_next = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Shift-add step: add multiplicand on LSB, shift {hi,lo} right.
  assign w_sum = {1'b0, r_hi}
               + (r_lo[0] ? {1'b0, r_a} : '0);

`ifdef MULDIV_DIV_EN
  // Restoring step: shift dividend MSB into the remainder,
  // subtract divisor when it fits, quotient bit enters lo.
  assign w_rsh    = {r_hi, r_lo[XLEN-1]};
  assign w_ge     = (w_rsh >= {1'b0, r_a});
  assign w_dif    = w_rsh[XLEN-1:0] - r_a;
  assign w_rem_nx = w_ge ? w_dif : w_rsh[XLEN-1:0];
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_op     <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg    <= 1'b0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_rd_q   <= '0;
      r_data_q <= '0;
`ifdef MULDIV_DIV_EN
      r_dz     <= 1'b0;
      r_rs1    <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_op  <= funct3_i;
        r_rd  <= RDaddr_i;
        r_neg <= w_neg;
        r_cnt <= '0;
        r_hi  <= '0;
`ifdef MULDIV_DIV_EN
        r_dz  <= (RS2data_i == '0);
        r_rs1 <= RS1data_i;
        if (funct3_i[2]) begin
          r_a  <= w_mag_b;
          r_lo <= w_mag_a;
        end else begin
          r_a  <= w_mag_a;
          r_lo <= w_mag_b;
        end
`else
        r_a   <= w_mag_a;
        r_lo  <= w_mag_b;
`endif
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + CW'(1);
`ifdef MULDIV_DIV_EN
        if (r_op[2]) begin
          r_hi <= w_rem_nx;
          r_lo <= {r_lo[XLEN-2:0], w_ge};
        end else begin
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
        end
`else
        r_hi  <= w_sum[XLEN:1];
        r_lo  <= {w_sum[0], r_lo[XLEN-1:1]};
`endif
      end
      if (w_done) begin
        r_rd_q   <= r_rd;
        r_data_q <= w_result;
      end
    end
  end

  // Sign fix-up happens here, in the DONE cycle.
  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_pfix   = r_neg ? -w_prod : w_prod;
    w_result = '0;
    unique case (r_op)
      3'd0:             w_result = w_pfix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: w_result = w_pfix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      3'd4, 3'd5: begin
        if (r_dz)       w_result = '1;
        else if (r_neg) w_result = -r_lo;
        else            w_result = r_lo;
      end
      3'd6, 3'd7: begin
        if (r_dz)       w_result = r_rs1;
        else if (r_neg) w_result = -r_hi;
        else            w_result = r_hi;
      end
`endif
      default: w_result = '0;
    endcase
  end

  // A flush or reset landing in DONE kills the pulse.
  assign w_done   = (r_state == DONE) && !flush_i && rst_i;
  assign done_o   = w_done;
  assign busy_o   = (r_state != IDLE);
  assign RDaddr_o = w_done ? r_rd : r_rd_q;
  assign RDdata_o = w_done ? w_result : r_data_q;
`ifdef MULDIV_DIV_EN
  assign RegWrite_o = w_done && (r_rd != '0);
`else
  assign RegWrite_o = w_done && (r_rd != '0) && !r_op[2];
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit with a
// transaction-level reference model checked every cycle.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_DIV_EN
  localparam logic [31:0] DMASK = 32'hFFFF_FFFF;
  localparam int          DLAT  = 33;
  localparam bit          DWB   = 1'b1;
`else
  localparam logic [31:0] DMASK = 32'h0;
  localparam int          DLAT  = 1;
  localparam bit          DWB   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] RS1data_i;
  logic [31:0] RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        RegWrite_o;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .flush_i   (flush_i),
    .funct3_i  (funct3_i),
    .RS1data_i (RS1data_i),
    .RS2data_i (RS2data_i),
    .RDaddr_i  (RDaddr_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .RDaddr_o  (RDaddr_o),
    .RDdata_o  (RDdata_o),
    .RegWrite_o(RegWrite_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: one operation in flight at most
  bit          m_pend = 0;
  int          m_due  = 0;
  int          m_bs   = 1;
  int          m_be   = 0;
  logic [4:0]  m_rd   = '0;
  logic [31:0] m_data = '0;
  logic        m_we   = 1'b0;
  logic [4:0]  m_hrd  = '0;
  logic [31:0] m_hdat = '0;
  int          m_busy_cnt = 0;
  bit          m_lit_on = 0;
  logic [31:0] m_lit  = '0;
  int          m_lit_lat = 0;
  int          m_k    = 0;

  function automatic logic [31:0] ref_res(
    input logic [2:0] f, input logic [31:0] a,
    input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    r  = '0;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ua * 0 + sa * longint'({32'b0, b})); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = 32'(sa / sb);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    if (f[2]) r = r & DMASK;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare();
    bit ed;
    bit eb;
    ed = m_pend && (cyc == m_due) && !flush_i && rst_i;
    eb = (cyc >= m_bs) && (cyc <= m_be);
    chk("busy_o", {31'b0, busy_o}, {31'b0, eb});
    chk("done_o", {31'b0, done_o}, {31'b0, ed});
    if (busy_o) m_busy_cnt++;
    if (done_o && m_lit_on) begin
      chk("literal", RDdata_o, m_lit);
      chk("latency", 32'(cyc - m_k), 32'(m_lit_lat));
      m_lit_on = 0;
    end
    if (ed) begin
      chk("RDaddr_o", {27'b0, RDaddr_o}, {27'b0, m_rd});
      chk("RDdata_o", RDdata_o, m_data);
      chk("RegWrite_o", {31'b0, RegWrite_o}, {31'b0, m_we});
      m_hrd  = m_rd;
      m_hdat = m_data;
      m_pend = 0;
    end else begin
      chk("hold_addr", {27'b0, RDaddr_o}, {27'b0, m_hrd});
      chk("hold_data", RDdata_o, m_hdat);
      chk("RegWrite_idle", {31'b0, RegWrite_o}, 32'b0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    start_i   = 1'b1;
    funct3_i  = f;
    RS1data_i = a;
    RS2data_i = b;
    RDaddr_i  = rd;
    if (!m_pend && !flush_i && rst_i) begin
      m_pend = 1;
      m_due  = cyc + (f[2] ? DLAT : 33);
      m_rd   = rd;
      m_data = ref_res(f, a, b);
      m_we   = (rd != 0) && (!f[2] || DWB);
      m_bs   = cyc + 1;
      m_be   = m_due;
    end
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (m_pend && g < 100) begin
      tick();
      g++;
    end
    if (m_pend) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout cyc=%0d got=no_done want=done", cyc);
      m_pend = 0;
    end
  endtask

  task automatic lit_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] lit, input int lat);
    m_lit     = lit;
    m_lit_lat = lat;
    m_lit_on  = 1;
    m_k       = cyc;
    do_op(f, a, b, rd);
    wait_idle();
    if (m_lit_on) begin
      n_cmp++;
      n_bad++;
      $display("FAIL literal_done cyc=%0d got=none want=%h", cyc, lit);
      m_lit_on = 0;
    end
  endtask

  task automatic flush_now();
    int k;
    k = cyc;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    m_pend = 0;
    if (m_be > k) m_be = k;
  endtask

  task automatic reset_now();
    int k;
    k = cyc;
    rst_i = 1'b0;
    tick();
    rst_i  = 1'b1;
    m_pend = 0;
    if (m_be > k) m_be = k;
    m_hrd  = '0;
    m_hdat = '0;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; RS1data_i = '0; RS2data_i = '0; RDaddr_i = '0;
    @(posedge clk);
    #1;
    tick();
    tick();

    // first start on the first edge with reset released
    rst_i = 1'b1;
    lit_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
    lit_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
           32'hFFFF_FFFE, 33);
    lit_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7,
           32'h4000_0000, 33);
    lit_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
    lit_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,
           32'h8000_0000 & DMASK, DLAT);
    lit_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, DLAT);
    lit_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11,
           32'hFFFF_FFFF & DMASK, DLAT);
    lit_op(3'd5, 32'd13, 32'd0, 5'd12, 32'hFFFF_FFFF & DMASK, DLAT);
    lit_op(3'd7, 32'd13, 32'd0, 5'd13, 32'd13 & DMASK, DLAT);
    lit_op(3'd4, 32'd100, 32'd7, 5'd0, 32'd14 & DMASK, DLAT);
    lit_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd14,
           32'hFFFF_FFFA & DMASK, DLAT);
    lit_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd15,
           32'hFFFF_FFFE & DMASK, DLAT);

    vecs.push_back('{3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd1});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'd1, 5'd2});
    vecs.push_back('{3'd1, 32'h7FFF_FFFF, 32'h8000_0001, 5'd3});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4});
    vecs.push_back('{3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd31});
    vecs.push_back('{3'd0, 32'h0, 32'hFFFF_FFFF, 5'd0});
    vecs.push_back('{3'd5, 32'hFFFF_FFFF, 32'd10, 5'd16});
    vecs.push_back('{3'd7, 32'hFFFF_FFFF, 32'd10, 5'd17});
    vecs.push_back('{3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 5'd18});
    vecs.push_back('{3'd6, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 5'd19});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0, 5'd20});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd0, 5'd21});
    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_idle();
    end

    // second start while busy must be dropped
    m_busy_cnt = 0;
    do_op(3'd0, 32'd3, 32'd5, 5'd9);
    repeat (4) tick();
    do_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd10);
    wait_idle();
    chk("busy_len", 32'(m_busy_cnt), 32'd33);

    // flush ten cycles after the start cycle
    do_op(3'd0, 32'd11, 32'd13, 5'd3);
    repeat (9) tick();
    flush_now();
    repeat (40) tick();

    // flush landing in the DONE cycle
    do_op(3'd1, 32'hFFFF_0000, 32'h0001_0000, 5'd4);
    while (cyc < m_due) tick();
    flush_now();
    repeat (3) tick();

    // reset in the middle of CALC
    do_op(3'd3, 32'h0000_FFFF, 32'h0000_FFFF, 5'd6);
    repeat (5) tick();
    reset_now();
    repeat (40) tick();

    lit_op(3'd0, 32'd6, 32'd7, 5'd2, 32'd42, 33);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
